// File: rtl/dm_lane_mem.sv
// Byte/half/word data memory for the MEM stage: lane-steered stores, registered
// sign/zero-extended loads, misalignment reporting and a post-reset clear sweep.
module dm_lane_mem #(
  parameter int DEPTH_LOG2 = 12,
  parameter bit INIT_CLEAR = 1'b1,
  parameter bit TRACE      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] Addr,
  input  logic [31:0] Data,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] DataOut,
  output logic        misalign
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic                    rvalid_q, rvalid_d;
  logic                    misalign_q, misalign_d;
  logic                    zero_q, zero_d;
  logic [1:0]              lsize_q, lsize_d;
  logic [1:0]              lane_q, lane_d;
  logic                    sext_q, sext_d;
  logic [31:0]             rword_q;

  logic [31:0]             mem [DEPTH];

  logic [DEPTH_LOG2-1:0]   idx;
  logic                    accept;
  logic                    bad;
  logic                    st_commit;
  logic                    ld_ok;
  logic                    sweep_we;
  logic [3:0]              be;
  logic [3:0]              wbe;
  logic [31:0]             wdata;
  logic [7:0]              rd_byte;
  logic [15:0]             rd_half;
  logic                    unused_ok;

  assign idx    = Addr[DEPTH_LOG2+1:2];
  assign accept = req & ready_q;

  always_comb begin
    unique case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = Addr[0];
      SZ_WORD: bad = |Addr[1:0];
      default: bad = 1'b1;
    endcase
  end

  // Gating with reset keeps a store that coincides with reset assertion from landing.
  assign st_commit = accept & we & ~bad & reset;
  assign ld_ok     = accept & ~we & ~bad;

  // NOTE: every variable assigned in a combinational block gets a default first,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    be    = 4'b0000;
    wdata = 32'h0;
    unique case (size)
      SZ_BYTE: begin
        be[Addr[1:0]] = 1'b1;
        wdata         = {4{Data[7:0]}};
      end
      SZ_HALF: begin
        be    = Addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{Data[15:0]}};
      end
      SZ_WORD: begin
        be    = 4'b1111;
        wdata = Data;
      end
      default: ;
    endcase
  end

  assign wbe = st_commit ? be : 4'b0000;

  // ---------------- sweep FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT_CLEAR ? S_INIT : S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- sweep FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = S_RUN;
      end
      S_RUN: ;
      default: state_d = S_RUN;
    endcase
  end

  // ---------------- sweep FSM: outputs ----------------
  always_comb begin
    sweep_we = (state_q == S_INIT);
    ready_d  = (state_d == S_RUN);
  end

  // Response bookkeeping; the load-lane metadata only moves on acceptance so
  // DataOut holds its last value while rvalid is low.
  always_comb begin
    rvalid_d   = accept;
    misalign_d = accept & bad;
    zero_d     = zero_q;
    lsize_d    = lsize_q;
    lane_d     = lane_q;
    sext_d     = sext_q;
    if (accept) begin
      zero_d  = ~ld_ok;
      lsize_d = size;
      lane_d  = Addr[1:0];
      sext_d  = sign_ext;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // from values sampled at the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
      zero_q     <= 1'b1;
      lsize_q    <= SZ_WORD;
      lane_q     <= 2'b00;
      sext_q     <= 1'b0;
    end else begin
      ready_q    <= ready_d;
      rvalid_q   <= rvalid_d;
      misalign_q <= misalign_d;
      zero_q     <= zero_d;
      lsize_q    <= lsize_d;
      lane_q     <= lane_d;
      sext_q     <= sext_d;
    end
  end

  // NOTE: the array and its read register carry no reset so they map onto RAM;
  // contents are cleared by the sweep and stale read data is masked by zero_q.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[cnt_q] <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (ld_ok) rword_q <= mem[idx];
  end

  always_comb begin
    rd_byte = rword_q[{lane_q, 3'b000} +: 8];
    rd_half = lane_q[1] ? rword_q[31:16] : rword_q[15:0];
    unique case (lsize_q)
      SZ_BYTE: DataOut = {{24{sext_q & rd_byte[7]}}, rd_byte};
      SZ_HALF: DataOut = {{16{sext_q & rd_half[15]}}, rd_half};
      default: DataOut = rword_q;
    endcase
    if (zero_q) DataOut = 32'h0;
  end

  assign ready    = ready_q;
  assign rvalid   = rvalid_q;
  assign misalign = misalign_q;

  assign unused_ok = ^{PC, Addr[31:DEPTH_LOG2+2]};

`ifndef SYNTHESIS
  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  lanes);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (lanes[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

  generate
    if (TRACE) begin : g_trace
      always @(posedge clk) begin
        if (st_commit && !sweep_we)
          $display("%d@%h: *%h <= %h", $time, PC, {Addr[31:2], 2'b00},
                   merge_word(mem[idx], wdata, be));
      end
    end
  endgenerate

  a_rvalid_needs_run: assert property (@(posedge clk) disable iff (!reset)
                                       rvalid_q |-> ($past(ready_q)));
  a_misalign_qual:    assert property (@(posedge clk) disable iff (!reset)
                                       misalign_q |-> rvalid_q);
`endif

endmodule
